// File: rtl/psum_accumulator_if.sv
// ----------------------------------------------------------------------------
// psum_accumulator_if
// Purpose : bundles the pixel-configuration, partial-sum and result-handshake
//           signals of psum_accumulator into one interface.
// Signals :
//   start, num_groups, bias, act_mode, relu6_max : per-pixel configuration
//   psum_in, psum_valid                           : partial-sum stream
//   out_data, out_valid, out_ready, out_sat       : result handshake
//   busy                                          : accumulator not in IDLE
// Modports: master = stimulus/consumer side, slave = accumulator side.
// ----------------------------------------------------------------------------
interface psum_accumulator_if #(
   parameter int DATA_WIDTH = 14
);
   logic                         start;
   logic [7:0]                   num_groups;
   logic signed [DATA_WIDTH-1:0] bias;
   logic [1:0]                   act_mode;
   logic signed [DATA_WIDTH-1:0] relu6_max;
   logic signed [DATA_WIDTH-1:0] psum_in;
   logic                         psum_valid;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_sat;
   logic                         busy;

   modport master (
      output start, num_groups, bias, act_mode, relu6_max, psum_in, psum_valid,
      output out_ready,
      input  out_data, out_valid, out_sat, busy
   );

   modport slave (
      input  start, num_groups, bias, act_mode, relu6_max, psum_in, psum_valid,
      input  out_ready,
      output out_data, out_valid, out_sat, busy
   );
endinterface

// File: rtl/psum_accumulator.sv
// ----------------------------------------------------------------------------
// psum_accumulator
// Purpose : accumulates num_groups signed partial sums for one output pixel,
//           adds a bias, clamps to the signed DATA_WIDTH range, applies an
//           optional ReLU / ReLU6 activation and presents the result through
//           a valid/ready handshake.
// Ports   :
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - psum_accumulator_if.slave (configuration, psum stream, result)
// Parameters:
//   DATA_WIDTH - width of psum, bias and result (signed)
//   ACC_WIDTH  - internal signed accumulator width
// ----------------------------------------------------------------------------
module psum_accumulator #(
   parameter int DATA_WIDTH = 14,
   parameter int ACC_WIDTH  = 22
) (
   input  logic                 clk,
   input  logic                 rst,
   psum_accumulator_if.slave    bus
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ACCUM = 3'd1;
   localparam logic [2:0] ST_BIAS  = 3'd2;
   localparam logic [2:0] ST_ACT   = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   // Clamp bounds expressed at accumulator width for the range compare, and
   // at data width for the clamped result.
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
      {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic signed [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   logic [2:0]                   state_q,    state_d;
   logic signed [ACC_WIDTH-1:0]  acc_q,      acc_d;
   logic [7:0]                   cnt_q,      cnt_d;
   logic [7:0]                   ngrp_q,     ngrp_d;
   logic signed [DATA_WIDTH-1:0] bias_q,     bias_d;
   logic [1:0]                   act_q,      act_d;
   logic signed [DATA_WIDTH-1:0] r6max_q,    r6max_d;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_sat_q,  out_sat_d;
   logic                         busy_q,     busy_d;

   logic signed [ACC_WIDTH-1:0]  psum_ext_s;
   logic signed [ACC_WIDTH-1:0]  bias_ext_s;
   logic signed [DATA_WIDTH-1:0] clamp_s;
   logic                         clamp_sat_s;
   logic signed [DATA_WIDTH-1:0] act_s;

   assign psum_ext_s = {{(ACC_WIDTH-DATA_WIDTH){bus.psum_in[DATA_WIDTH-1]}}, bus.psum_in};
   assign bias_ext_s = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

   // Saturate the accumulator into the signed DATA_WIDTH range.
   always_comb begin
      clamp_s     = acc_q[DATA_WIDTH-1:0];
      clamp_sat_s = 1'b0;
      if (acc_q > ACC_MAX) begin
         clamp_s     = DATA_MAX;
         clamp_sat_s = 1'b1;
      end else if (acc_q < ACC_MIN) begin
         clamp_s     = DATA_MIN;
         clamp_sat_s = 1'b1;
      end else begin
         clamp_s     = acc_q[DATA_WIDTH-1:0];
         clamp_sat_s = 1'b0;
      end
   end

   // Activation runs on the clamped value; out_sat reflects only the clamp.
   always_comb begin
      act_s = clamp_s;
      case (act_q)
         2'b01: begin
            if (clamp_s[DATA_WIDTH-1]) begin
               act_s = DATA_ZERO;
            end else begin
               act_s = clamp_s;
            end
         end
         2'b10: begin
            if (clamp_s[DATA_WIDTH-1]) begin
               act_s = DATA_ZERO;
            end else if (clamp_s > r6max_q) begin
               act_s = r6max_q;
            end else begin
               act_s = clamp_s;
            end
         end
         default: act_s = clamp_s;
      endcase
   end

   // Control FSM and datapath next-state.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      ngrp_d      = ngrp_q;
      bias_d      = bias_q;
      act_d       = act_q;
      r6max_d     = r6max_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      case (state_q)
         ST_IDLE: begin
            // A psum_valid coinciding with start is deliberately dropped.
            if (bus.start) begin
               acc_d   = {ACC_WIDTH{1'b0}};
               cnt_d   = 8'd0;
               ngrp_d  = (bus.num_groups == 8'd0) ? 8'd1 : bus.num_groups;
               bias_d  = bus.bias;
               act_d   = bus.act_mode;
               r6max_d = bus.relu6_max;
               state_d = ST_ACCUM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (bus.psum_valid) begin
               acc_d = acc_q + psum_ext_s;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == (ngrp_q - 8'd1)) begin
                  state_d = ST_BIAS;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_BIAS: begin
            acc_d   = acc_q + bias_ext_s;
            state_d = ST_ACT;
         end
         ST_ACT: begin
            out_data_d  = act_s;
            out_sat_d   = clamp_sat_s;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State registers with synchronous reset taking priority over all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= {ACC_WIDTH{1'b0}};
         cnt_q       <= 8'd0;
         ngrp_q      <= 8'd1;
         bias_q      <= DATA_ZERO;
         act_q       <= 2'b00;
         r6max_q     <= DATA_ZERO;
         out_data_q  <= DATA_ZERO;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ngrp_q      <= ngrp_d;
         bias_q      <= bias_d;
         act_q       <= act_d;
         r6max_q     <= r6max_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.busy      = busy_q;

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 14: width of partial sums, bias and result, all two's-complement signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 22: internal signed accumulator width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse opening a new output pixel.
REQ-006 SHALL have port num_groups, input, 8: partial sums per pixel; sampled on the accepted start; value 0 treated as 1.
REQ-007 SHALL have port bias, input, DATA_WIDTH: signed bias; sampled on the accepted start.
REQ-008 SHALL have port act_mode, input, 2: sampled on the accepted start; 00 none, 01 ReLU, 10 ReLU6, 11 treated as none.
REQ-009 SHALL have port relu6_max, input, DATA_WIDTH: non-negative ReLU6 ceiling in fixed point; sampled on the accepted start.
REQ-010 SHALL have port psum_in, input, DATA_WIDTH: partial sum from the upstream 27-input adder tree.
REQ-011 SHALL have port psum_valid, input, 1: one-cycle qualifier for psum_in (adder data_valid).
REQ-012 SHALL have port out_data, output, DATA_WIDTH: registered activated result.
REQ-013 SHALL have port out_valid, output, 1: result available.
REQ-014 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-015 SHALL have port out_sat, output, 1: result was clamped to the signed DATA_WIDTH range; valid with out_valid.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, BIAS, ACT, HOLD.
REQ-018 IDLE: start=1 SHALL clear accumulator and group counter, latch configuration, go to ACCUM; a psum_valid in the same cycle is ignored.
REQ-019 ACCUM: each cycle with psum_valid=1 SHALL add sign-extended psum_in to the accumulator and increment the counter.
REQ-020 ACCUM: the psum accepted with counter = effective num_groups-1 SHALL be added, then the FSM goes to BIAS.
REQ-021 BIAS: accumulator SHALL add sign-extended latched bias, go to ACT.
REQ-022 ACT: SHALL register out_data and out_sat, set out_valid=1, go to HOLD.
REQ-023 HOLD: out_data, out_sat and out_valid SHALL hold stable while out_ready=0.
REQ-024 HOLD with out_ready=1 SHALL clear out_valid on that edge and return to IDLE; the next start is accepted the following cycle.
REQ-025 Latency: out_valid SHALL rise exactly 2 cycles after the edge that accepts the last psum.
REQ-026 Accumulator SHALL never wrap: 255 x max |psum| + |bias| fits ACC_WIDTH=22.
REQ-027 Signed clamp SHALL use range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; out_sat=1 only when this clamp changes the value.
REQ-028 Activation SHALL be applied after the clamp: none passes through; ReLU maps negative to 0; ReLU6 maps to min(max(x,0), relu6_max).
REQ-029 start SHALL be ignored outside IDLE; configuration inputs SHALL be ignored except when start is accepted.
REQ-030 psum_valid SHALL be ignored in IDLE, BIAS, ACT and HOLD (dropped, no error).

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, zero the accumulator and counter, and set out_data=0, out_valid=0, out_sat=0, busy=0, in any state, including mid-accumulation and HOLD.
REQ-032 rst SHALL take priority over start, psum_valid and out_ready in the same cycle.

Verification
REQ-033 Basic: start with num_groups=3, bias=5, act_mode=00; psums 100, -20, 7 -> out_data=92, out_sat=0, out_valid 2 cycles after the third psum.
REQ-034 Saturation: num_groups=2, bias=0, psums 8000, 8000 -> out_data=8191, out_sat=1; negative variant with -8000, -8000 -> -8192, out_sat=1.
REQ-035 Activation: num_groups=1, bias=-10, psum 4 -> act 00 gives -6, 01 gives 0; act 10 with relu6_max=384 and psum 1000 gives 384, out_sat=0.
REQ-036 Backpressure: out_ready low for 5 cycles in HOLD -> out_data and out_valid stable, psum_valid pulses and start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Reset mid-operation: rst after 1 of 4 psums -> all outputs 0, busy=0; a new start with num_groups=1, psum 9, bias 0 -> out_data=9.
REQ-038 Boundaries: num_groups=0 with psum 11 -> out_data=11 after one psum; num_groups=255 with psum 8191 each and bias 8191 -> out_data=8191, out_sat=1, no accumulator wrap.
